// File: rtl/ctrl_pkg.sv
// Shared constants and types for the processor-core instruction sequencer.
// Class encodings, state enum, datapath select codes and error codes.
package ctrl_pkg;

  localparam int CLASS_WIDTH = 5;

  localparam logic [4:0] PULSE_I     = 5'b10010;
  localparam logic [4:0] REG_I_ALU   = 5'b00010;
  localparam logic [4:0] REG_ALU     = 5'b00011;
  localparam logic [4:0] JUMP_I      = 5'b00100;
  localparam logic [4:0] JUMP_COND_I = 5'b00110;
  localparam logic [4:0] JUMP_COND   = 5'b00111;
  localparam logic [4:0] INC_QCLK_I  = 5'b01000;
  localparam logic [4:0] INC_QCLK    = 5'b01001;
  localparam logic [4:0] FPROC       = 5'b01010;
  localparam logic [4:0] SYNC        = 5'b01100;
  localparam logic [4:0] DONE_I      = 5'b01110;

  typedef enum logic [2:0] {
    S_INIT,
    S_ALU_PROC,
    S_JUMP_COND,
    S_INC_QCLK,
    S_FPROC_WAIT,
    S_SYNC_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic       ALU0_CMD   = 1'b0;
  localparam logic       ALU0_REG   = 1'b1;
  localparam logic [1:0] ALU1_REG   = 2'd0;
  localparam logic [1:0] ALU1_QCLK  = 2'd1;
  localparam logic [1:0] IP_INC     = 2'd0;
  localparam logic [1:0] IP_CMD     = 2'd1;
  localparam logic [1:0] IP_ALU     = 2'd2;
  localparam logic       WSEL_ALU   = 1'b0;
  localparam logic       WSEL_FPROC = 1'b1;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_FPROC_TO = 2'd2;
  localparam logic [1:0] ERR_SYNC_TO  = 2'd3;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Wait-state cycle counter: clears outside the wait states, counts unanswered
// wait cycles, saturates, and flags the last permitted cycle.
module ctrl_wait_timer #(
  parameter int TIMEOUT_WIDTH = 16,
  parameter int WAIT_TIMEOUT  = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [TIMEOUT_WIDTH-1:0] LIMIT =
    (WAIT_TIMEOUT > 0) ? TIMEOUT_WIDTH'(WAIT_TIMEOUT - 1) : '0;

  logic [TIMEOUT_WIDTH-1:0] count_q;
  logic [TIMEOUT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero timeout means wait forever.
  assign expired = (WAIT_TIMEOUT > 0) && (count_q == LIMIT);

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Instruction-sequencing controller for one distributed-processor core:
// decodes the opcode class and steps through multi-cycle instruction sequences.
//
// state        | meaning
// INIT         | decode opcode class, issue single-cycle instructions
// ALU_PROC     | write ALU result to register file, advance IP
// JUMP_COND    | load IP from ALU-conditional source
// INC_QCLK     | load ALU result into qclk, advance IP
// FPROC_WAIT   | function-processor request pending
// SYNC_WAIT    | sync barrier request pending
// DONE         | halted after DONE_I (absorbing)
// ERR          | halted on error, err_code holds cause (absorbing)
module proc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH  = 8,
  parameter int ALU_OP_WIDTH  = 3,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int WAIT_TIMEOUT  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    cstrobe_in,
  input  logic                    fproc_enable,
  input  logic                    sync_enable,
  output logic [ALU_OP_WIDTH-1:0] alu_opcode,
  output logic                    alu_in0_sel,
  output logic [1:0]              alu_in1_sel,
  output logic                    reg_write_en,
  output logic                    reg_write_sel,
  output logic                    c_strobe_enable,
  output logic                    instr_ptr_en,
  output logic [1:0]              instr_ptr_load_en,
  output logic                    qclk_load_en,
  output logic                    fproc_out_ready,
  output logic                    sync_out_ready,
  output logic                    done,
  output logic [1:0]              err_code
);

  state_e     state_q, state_d;
  logic [1:0] err_q, err_d;

  logic [CLASS_WIDTH-1:0] op_class;
  logic                   fproc_resp, sync_resp;
  logic                   in_wait, timer_expired;
  logic                   unused_opcode_bits;

  assign op_class           = opcode[OPCODE_WIDTH-1 -: CLASS_WIDTH];
  assign alu_opcode         = opcode[ALU_OP_WIDTH-1:0];
  assign unused_opcode_bits = ^opcode;
  assign err_code           = err_q;

  // A response arriving while reset is asserted must not strobe the datapath.
  assign fproc_resp = fproc_enable && !reset;
  assign sync_resp  = sync_enable && !reset;
  assign in_wait    = (state_q == S_FPROC_WAIT) || (state_q == S_SYNC_WAIT);

  ctrl_wait_timer #(
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH),
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_wait),
    .inc    ((state_q == S_FPROC_WAIT && !fproc_resp) ||
             (state_q == S_SYNC_WAIT && !sync_resp)),
    .expired(timer_expired)
  );

  always_comb begin
    state_d           = state_q;
    err_d             = err_q;
    alu_in0_sel       = ALU0_CMD;
    alu_in1_sel       = ALU1_REG;
    reg_write_en      = 1'b0;
    reg_write_sel     = WSEL_ALU;
    c_strobe_enable   = 1'b0;
    instr_ptr_en      = 1'b0;
    instr_ptr_load_en = IP_INC;
    qclk_load_en      = 1'b0;
    fproc_out_ready   = 1'b0;
    sync_out_ready    = 1'b0;
    done              = 1'b0;

    case (state_q)
      S_INIT: begin
        case (op_class)
          PULSE_I: begin
            c_strobe_enable = 1'b1;
            instr_ptr_en    = cstrobe_in;
          end
          REG_I_ALU, REG_ALU: begin
            alu_in0_sel = (op_class == REG_ALU) ? ALU0_REG : ALU0_CMD;
            state_d     = S_ALU_PROC;
          end
          JUMP_I: begin
            instr_ptr_load_en = IP_CMD;
            instr_ptr_en      = 1'b1;
          end
          JUMP_COND_I, JUMP_COND: begin
            alu_in0_sel = (op_class == JUMP_COND) ? ALU0_REG : ALU0_CMD;
            state_d     = S_JUMP_COND;
          end
          INC_QCLK_I, INC_QCLK: begin
            alu_in0_sel = (op_class == INC_QCLK) ? ALU0_REG : ALU0_CMD;
            alu_in1_sel = ALU1_QCLK;
            state_d     = S_INC_QCLK;
          end
          FPROC:   state_d = S_FPROC_WAIT;
          SYNC:    state_d = S_SYNC_WAIT;
          DONE_I:  state_d = S_DONE;
          default: begin
            state_d = S_ERR;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_ALU_PROC: begin
        reg_write_en = 1'b1;
        instr_ptr_en = 1'b1;
        state_d      = S_INIT;
      end
      S_JUMP_COND: begin
        instr_ptr_load_en = IP_ALU;
        instr_ptr_en      = 1'b1;
        state_d           = S_INIT;
      end
      S_INC_QCLK: begin
        qclk_load_en = 1'b1;
        instr_ptr_en = 1'b1;
        state_d      = S_INIT;
      end
      S_FPROC_WAIT: begin
        fproc_out_ready = 1'b1;
        if (fproc_resp) begin
          reg_write_en  = 1'b1;
          reg_write_sel = WSEL_FPROC;
          instr_ptr_en  = 1'b1;
          state_d       = S_INIT;
        end else if (timer_expired) begin
          state_d = S_ERR;
          err_d   = ERR_FPROC_TO;
        end
      end
      S_SYNC_WAIT: begin
        sync_out_ready = 1'b1;
        if (sync_resp) begin
          instr_ptr_en = 1'b1;
          state_d      = S_INIT;
        end else if (timer_expired) begin
          state_d = S_ERR;
          err_d   = ERR_SYNC_TO;
        end
      end
      S_DONE:  done = 1'b1;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed bench for proc_ctrl_fsm: one instance without timeout, one with a
// four-cycle timeout, both driven by the same stimulus.
module tb_proc_ctrl_fsm;
  import ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] alu_opcode;
    logic       alu_in0_sel;
    logic [1:0] alu_in1_sel;
    logic       reg_write_en;
    logic       reg_write_sel;
    logic       c_strobe_enable;
    logic       instr_ptr_en;
    logic [1:0] instr_ptr_load_en;
    logic       qclk_load_en;
    logic       fproc_out_ready;
    logic       sync_out_ready;
    logic       done;
    logic [1:0] err_code;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] opcode;
  logic       cstrobe_in, fproc_enable, sync_enable;

  logic [2:0] a_alu_opcode, b_alu_opcode;
  logic       a_in0, b_in0;
  logic [1:0] a_in1, b_in1;
  logic       a_rwe, b_rwe, a_rws, b_rws, a_cse, b_cse, a_ipe, b_ipe;
  logic [1:0] a_ipl, b_ipl;
  logic       a_qle, b_qle, a_fr, b_fr, a_sr, b_sr, a_done, b_done;
  logic [1:0] a_err, b_err;

  outs_t obs_a, obs_b;

  outs_t exp_q[$];
  string tag_q[$];
  int    inst_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  proc_ctrl_fsm #(.WAIT_TIMEOUT(0)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .cstrobe_in(cstrobe_in),
    .fproc_enable(fproc_enable), .sync_enable(sync_enable),
    .alu_opcode(a_alu_opcode), .alu_in0_sel(a_in0), .alu_in1_sel(a_in1),
    .reg_write_en(a_rwe), .reg_write_sel(a_rws), .c_strobe_enable(a_cse),
    .instr_ptr_en(a_ipe), .instr_ptr_load_en(a_ipl), .qclk_load_en(a_qle),
    .fproc_out_ready(a_fr), .sync_out_ready(a_sr), .done(a_done),
    .err_code(a_err)
  );

  proc_ctrl_fsm #(.WAIT_TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .cstrobe_in(cstrobe_in),
    .fproc_enable(fproc_enable), .sync_enable(sync_enable),
    .alu_opcode(b_alu_opcode), .alu_in0_sel(b_in0), .alu_in1_sel(b_in1),
    .reg_write_en(b_rwe), .reg_write_sel(b_rws), .c_strobe_enable(b_cse),
    .instr_ptr_en(b_ipe), .instr_ptr_load_en(b_ipl), .qclk_load_en(b_qle),
    .fproc_out_ready(b_fr), .sync_out_ready(b_sr), .done(b_done),
    .err_code(b_err)
  );

  assign obs_a = {a_alu_opcode, a_in0, a_in1, a_rwe, a_rws, a_cse, a_ipe,
                  a_ipl, a_qle, a_fr, a_sr, a_done, a_err};
  assign obs_b = {b_alu_opcode, b_in0, b_in1, b_rwe, b_rws, b_cse, b_ipe,
                  b_ipl, b_qle, b_fr, b_sr, b_done, b_err};

  function automatic outs_t base();
    outs_t r;
    r = '0;
    r.alu_opcode = opcode[2:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expectation for this cycle, compare at the falling edge, then
  // advance to just after the next rising edge.
  task automatic step(input int inst, input string tag, input outs_t e);
    outs_t ex, o;
    string t;
    int    which;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    inst_q.push_back(inst);
    @(negedge clk);
    ex    = exp_q.pop_front();
    t     = tag_q.pop_front();
    which = inst_q.pop_front();
    o     = (which == 0) ? obs_a : obs_b;
    n_checks++;
    assert (o === ex) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, o, ex);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    outs_t e;
    reset        = 1'b1;
    opcode       = {REG_ALU, 3'b101};
    cstrobe_in   = 1'b0;
    fproc_enable = 1'b0;
    sync_enable  = 1'b0;
    tick();

    e = base(); e.alu_in0_sel = 1'b1;
    step(1, "reset_decode_b", e);
    reset = 1'b0;

    e = base(); e.alu_in0_sel = 1'b1;
    step(0, "reg_alu_decode", e);
    e = base(); e.reg_write_en = 1'b1; e.instr_ptr_en = 1'b1;
    step(0, "reg_alu_exec", e);

    opcode = {JUMP_I, 3'b000};
    e = base(); e.instr_ptr_load_en = 2'd1; e.instr_ptr_en = 1'b1;
    step(0, "jump_i", e);

    opcode = {PULSE_I, 3'b011};
    for (int i = 0; i < 5; i++) begin
      e = base(); e.c_strobe_enable = 1'b1;
      step(0, "pulse_hold", e);
    end
    cstrobe_in = 1'b1;
    e = base(); e.c_strobe_enable = 1'b1; e.instr_ptr_en = 1'b1;
    step(0, "pulse_fire", e);
    cstrobe_in = 1'b0;

    opcode       = {JUMP_COND_I, 3'b110};
    fproc_enable = 1'b1;
    sync_enable  = 1'b1;
    e = base();
    step(0, "jcond_i_decode", e);
    fproc_enable = 1'b0;
    sync_enable  = 1'b0;
    e = base(); e.instr_ptr_load_en = 2'd2; e.instr_ptr_en = 1'b1;
    step(0, "jcond_exec", e);

    opcode = {INC_QCLK, 3'b001};
    e = base(); e.alu_in0_sel = 1'b1; e.alu_in1_sel = 2'd1;
    step(0, "incq_decode", e);
    e = base(); e.qclk_load_en = 1'b1; e.instr_ptr_en = 1'b1;
    step(0, "incq_exec", e);

    opcode = {REG_I_ALU, 3'b010};
    e = base();
    step(0, "reg_i_alu_decode", e);
    e = base(); e.reg_write_en = 1'b1; e.instr_ptr_en = 1'b1;
    step(0, "reg_i_alu_exec", e);

    opcode = {FPROC, 3'b000};
    e = base();
    step(0, "fproc_decode", e);
    for (int i = 0; i < 6; i++) begin
      e = base(); e.fproc_out_ready = 1'b1;
      step(0, "fproc_wait", e);
    end
    fproc_enable = 1'b1;
    e = base(); e.fproc_out_ready = 1'b1; e.reg_write_en = 1'b1;
    e.reg_write_sel = 1'b1; e.instr_ptr_en = 1'b1;
    step(0, "fproc_done", e);
    fproc_enable = 1'b0;
    opcode = {JUMP_I, 3'b000};
    e = base(); e.instr_ptr_load_en = 2'd1; e.instr_ptr_en = 1'b1;
    step(0, "after_fproc", e);
    e = base(); e.err_code = 2'd2;
    step(1, "fproc_timeout_b", e);

    reset  = 1'b1;
    opcode = {SYNC, 3'b000};
    tick();
    reset = 1'b0;
    e = base();
    step(1, "sync_decode_b", e);
    for (int i = 0; i < 4; i++) begin
      e = base(); e.sync_out_ready = 1'b1;
      step(1, "sync_wait_b", e);
    end
    opcode = {JUMP_I, 3'b111};
    for (int i = 0; i < 2; i++) begin
      e = base(); e.err_code = 2'd3;
      step(1, "sync_timeout_b", e);
    end
    e = base(); e.sync_out_ready = 1'b1;
    step(0, "no_timeout_a", e);

    reset       = 1'b1;
    sync_enable = 1'b1;
    e = base(); e.sync_out_ready = 1'b1;
    step(0, "reset_mid_wait", e);
    reset       = 1'b0;
    sync_enable = 1'b0;
    opcode      = {SYNC, 3'b000};
    e = base();
    step(0, "after_reset_a", e);

    for (int i = 0; i < 3; i++) begin
      e = base(); e.sync_out_ready = 1'b1;
      step(1, "coinc_wait_b", e);
    end
    sync_enable = 1'b1;
    e = base(); e.sync_out_ready = 1'b1; e.instr_ptr_en = 1'b1;
    step(1, "coinc_resp_b", e);
    sync_enable = 1'b0;
    opcode = {JUMP_I, 3'b000};
    e = base(); e.instr_ptr_load_en = 2'd1; e.instr_ptr_en = 1'b1;
    step(1, "coinc_after_b", e);

    opcode = {5'b11111, 3'b010};
    e = base();
    step(0, "illegal_decode", e);
    opcode = {REG_ALU, 3'b001};
    for (int i = 0; i < 2; i++) begin
      e = base(); e.err_code = 2'd1;
      step(0, "illegal_sticky", e);
    end

    reset  = 1'b1;
    opcode = {DONE_I, 3'b100};
    tick();
    reset = 1'b0;
    e = base();
    step(0, "done_decode", e);
    cstrobe_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode = {PULSE_I, 3'(i)};
      e = base(); e.done = 1'b1;
      step(0, "done_hold", e);
    end
    cstrobe_in = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
